// File: rtl/stride_updown_counter_pkg.sv
// Shared definitions for the stride up/down counter.
//   mode_t   : operating mode encodings (wrap, saturate, bounce, reserved)
//   calc_max : highest value of the sequence BASE, BASE+STRIDE, ... in WIDTH bits
//   is_legal : true when a value lies on the sequence between BASE and the top value
package stride_updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    function automatic int calc_max(input int width, input int base, input int stride);
        return base + stride * (((2 ** width) - 1 - base) / stride);
    endfunction

    function automatic logic is_legal(input int v, input int base, input int max_v,
                                      input int stride);
        return (v >= base) && (v <= max_v) && (((v - base) % stride) == 0);
    endfunction

endpackage

// File: rtl/stride_updown_counter_if.sv
// Control/status bundle of the stride up/down counter.
//   en, Y, mode, load, load_val : requests into the counter
//   Q, dir, tc, err             : registered counter state and pulses
// The slave modport is the counter side, master is the controlling side.
interface stride_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             Y;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             dir;
    logic             tc;
    logic             err;

    modport slave (
        input  en, Y, mode, load, load_val,
        output Q, dir, tc, err
    );

    modport master (
        output en, Y, mode, load, load_val,
        input  Q, dir, tc, err
    );
endinterface

// File: rtl/stride_updown_counter_next_calc.sv
// Combinational next-value calculation for the stride counter.
//   q       : current count
//   dir_eff : direction to step in (1 = up)
//   mode    : wrap / saturate / bounce / reserved
//   next_q, next_dir : proposed next count and direction
//   hit_tc  : a boundary was reached on this step
//   illegal : q is not on the sequence
module stride_updown_counter_next_calc
    import stride_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 2,
    parameter int BASE   = 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir_eff,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_q,
    output logic             next_dir,
    output logic             hit_tc,
    output logic             illegal
);
    localparam int MAX_VAL  = calc_max(WIDTH, BASE, STRIDE);
    localparam int TOP_TURN = MAX_VAL - STRIDE;
    localparam int BOT_TURN = BASE + STRIDE;

    localparam logic [WIDTH:0]   BASE_X   = BASE[WIDTH:0];
    localparam logic [WIDTH:0]   STRIDE_X = STRIDE[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_X    = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH-1:0] BASE_Q   = BASE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_Q    = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TOP_Q    = TOP_TURN[WIDTH-1:0];
    localparam logic [WIDTH-1:0] BOT_Q    = BOT_TURN[WIDTH-1:0];

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           at_top;
    logic           at_bot;

    // One extra bit so a step past either end is visible instead of aliasing.
    assign q_ext   = {1'b0, q};
    assign up_sum  = q_ext + STRIDE_X;
    assign dn_diff = q_ext - STRIDE_X;
    assign at_top  = (up_sum > MAX_X);
    assign at_bot  = dn_diff[WIDTH] || (dn_diff < BASE_X);

    assign illegal = !is_legal(int'(q), BASE, MAX_VAL, STRIDE);

    always_comb begin
        next_q   = q;
        next_dir = dir_eff;
        hit_tc   = 1'b0;
        case (mode)
            MODE_WRAP: begin
                if (dir_eff) begin
                    if (at_top) begin
                        next_q = BASE_Q;
                        hit_tc = 1'b1;
                    end else begin
                        next_q = up_sum[WIDTH-1:0];
                    end
                end else begin
                    if (at_bot) begin
                        next_q = MAX_Q;
                        hit_tc = 1'b1;
                    end else begin
                        next_q = dn_diff[WIDTH-1:0];
                    end
                end
            end
            MODE_SAT: begin
                if (dir_eff) begin
                    if (at_top) hit_tc = 1'b1;
                    else        next_q = up_sum[WIDTH-1:0];
                end else begin
                    if (at_bot) hit_tc = 1'b1;
                    else        next_q = dn_diff[WIDTH-1:0];
                end
            end
            MODE_BOUNCE: begin
                if (dir_eff) begin
                    if (at_top) begin
                        next_q   = TOP_Q;
                        next_dir = 1'b0;
                        hit_tc   = 1'b1;
                    end else begin
                        next_q = up_sum[WIDTH-1:0];
                    end
                end else begin
                    if (at_bot) begin
                        next_q   = BOT_Q;
                        next_dir = 1'b1;
                        hit_tc   = 1'b1;
                    end else begin
                        next_q = dn_diff[WIDTH-1:0];
                    end
                end
            end
            default: begin
                next_q   = q;
                next_dir = dir_eff;
            end
        endcase
    end

endmodule

// File: rtl/stride_updown_counter.sv
// Up/down counter over BASE, BASE+STRIDE, ... MAX_VAL with wrap, saturate and
// bounce modes, validated synchronous load, terminal-count and error pulses.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (Q=BASE, dir=up, tc=err=0)
//   bus : slave side of stride_updown_counter_if
//         in  en, Y (1=up), mode, load, load_val
//         out Q, dir, tc, err
module stride_updown_counter
    import stride_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 2,
    parameter int BASE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    stride_updown_counter_if.slave  bus
);
    localparam int MAX_VAL = calc_max(WIDTH, BASE, STRIDE);
    localparam logic [WIDTH-1:0] BASE_Q = BASE[WIDTH-1:0];

    generate
        if (MAX_VAL == BASE) begin : g_bad_params
            $error("stride_updown_counter: sequence has a single value");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic             dir_r;
    logic             tc_r;
    logic             err_r;

    mode_t            mode;
    logic             dir_eff;
    logic             load_ok;
    logic [WIDTH-1:0] next_q;
    logic             next_dir;
    logic             hit_tc;
    logic             illegal;

    assign mode    = mode_t'(bus.mode);
    // Bounce follows its own direction register; Y only steers the other modes.
    assign dir_eff = (mode == MODE_BOUNCE || mode == MODE_RSVD) ? dir_r : bus.Y;
    assign load_ok = is_legal(int'(bus.load_val), BASE, MAX_VAL, STRIDE);

    stride_updown_counter_next_calc #(
        .WIDTH  (WIDTH),
        .STRIDE (STRIDE),
        .BASE   (BASE)
    ) u_next_calc (
        .q        (q_r),
        .dir_eff  (dir_eff),
        .mode     (mode),
        .next_q   (next_q),
        .next_dir (next_dir),
        .hit_tc   (hit_tc),
        .illegal  (illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= BASE_Q;
            dir_r <= 1'b1;
            tc_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            tc_r  <= 1'b0;
            err_r <= 1'b0;
            if (bus.load) begin
                if (load_ok) q_r   <= bus.load_val;
                else         err_r <= 1'b1;
            end else if (bus.en) begin
                if (mode == MODE_RSVD) begin
                    err_r <= 1'b1;
                end else if (illegal) begin
                    // Recovery path for a corrupted count.
                    q_r   <= BASE_Q;
                    err_r <= 1'b1;
                end else begin
                    q_r   <= next_q;
                    dir_r <= next_dir;
                    tc_r  <= hit_tc;
                end
            end
        end
    end

    assign bus.Q   = q_r;
    assign bus.dir = dir_r;
    assign bus.tc  = tc_r;
    assign bus.err = err_r;

endmodule
